// File: rtl/chacha_keystream_ctrl.sv
// Keystream scheduler in front of a fixed-latency pipelined ChaCha20 block core.
// Arbitrates two requesters round-robin, issues one block state per cycle while
// output credit remains, tracks in-flight blocks with a tag pipe and buffers the
// core results in an output FIFO so no result is ever dropped.
module chacha_keystream_ctrl #(
    parameter int CORE_LAT   = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [255:0]       key,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [191:0]       req_nonce,
    input  logic [63:0]        req_ctr,
    input  logic [2*LEN_W-1:0] req_len,
    output logic [511:0]       core_state,
    output logic               core_issue,
    input  logic [511:0]       core_result,
    output logic               ks_valid,
    input  logic               ks_ready,
    output logic [511:0]       ks_data,
    output logic               ks_id,
    output logic               ks_last,
    output logic               busy
);
    localparam logic [127:0] SIGMA = 128'h61707865_3320646e_79622d32_6b206574;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW:0]   CREDITS   = (CW+1)'(FIFO_DEPTH);
    localparam logic [AW-1:0] LAST_SLOT = AW'(FIFO_DEPTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    typedef struct packed {
        logic v;
        logic id;
        logic last;
    } tag_t;

    logic [0:0]       state;
    logic             rr_ptr;
    logic [255:0]     key_q;
    logic [31:0]      ctr_q;
    logic [95:0]      nonce_q;
    logic [LEN_W-1:0] rem_q;
    logic             id_q;

    tag_t [CORE_LAT:0] tag_pipe;
    tag_t              tag_out;
    logic [CW-1:0]     inflight;
    logic [CW-1:0]     fcnt;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [511:0]      mem_data [FIFO_DEPTH];
    logic              mem_id   [FIFO_DEPTH];
    logic              mem_last [FIFO_DEPTH];

    logic             gnt;
    logic             grant;
    logic             credit_ok;
    logic             do_issue;
    logic             push;
    logic             pop;
    logic [31:0]      g_ctr;
    logic [95:0]      g_nonce;
    logic [LEN_W-1:0] g_len;

    // rr_ptr has priority; otherwise the other requester gets the grant.
    // A grant is withheld while the previous accept pulse is still visible so a
    // requester that has not yet dropped valid is not accepted twice.
    assign gnt     = req_valid[rr_ptr] ? rr_ptr : ~rr_ptr;
    assign grant   = (state == S_IDLE) && (|req_valid) && !(|req_ready);
    assign g_ctr   = gnt ? req_ctr[63:32]   : req_ctr[31:0];
    assign g_nonce = gnt ? req_nonce[191:96] : req_nonce[95:0];
    assign g_len   = gnt ? req_len[2*LEN_W-1:LEN_W] : req_len[LEN_W-1:0];

    // Credit counts blocks in the core plus blocks parked in the FIFO, using
    // registered values only, so the FIFO always has room for every result.
    assign credit_ok = ({1'b0, inflight} + {1'b0, fcnt}) < CREDITS;
    assign do_issue  = (state == S_ISSUE) && credit_ok;

    assign tag_out = tag_pipe[CORE_LAT];
    assign push    = tag_out.v;
    assign pop     = ks_valid && ks_ready;

    // Arbitration, burst registers and registered core issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            rr_ptr     <= 1'b0;
            req_ready  <= 2'b00;
            key_q      <= '0;
            ctr_q      <= '0;
            nonce_q    <= '0;
            rem_q      <= '0;
            id_q       <= 1'b0;
            core_issue <= 1'b0;
            core_state <= '0;
        end else begin
            req_ready  <= 2'b00;
            core_issue <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant) begin
                        req_ready <= gnt ? 2'b10 : 2'b01;
                        rr_ptr    <= ~gnt;
                        id_q      <= gnt;
                        key_q     <= key;
                        ctr_q     <= g_ctr;
                        nonce_q   <= g_nonce;
                        rem_q     <= g_len;
                        if (g_len != '0) state <= S_ISSUE;
                    end
                end
                default: begin
                    if (do_issue) begin
                        core_issue <= 1'b1;
                        core_state <= {SIGMA, key_q, ctr_q, nonce_q};
                        ctr_q      <= ctr_q + 32'd1;
                        rem_q      <= rem_q - LEN_W'(1);
                        if (rem_q == LEN_W'(1)) state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Tag pipe aligned with the core latency; stage 0 loads with core_issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
            inflight <= '0;
        end else begin
            tag_pipe[0].v    <= do_issue;
            tag_pipe[0].id   <= do_issue & id_q;
            tag_pipe[0].last <= do_issue & (rem_q == LEN_W'(1));
            for (int i = 1; i <= CORE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
            if (do_issue && !push)      inflight <= inflight + CW'(1);
            else if (!do_issue && push) inflight <= inflight - CW'(1);
        end
    end

    // FIFO storage; contents are don't-care until a slot is written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_ptr] <= core_result;
            mem_id[wr_ptr]   <= tag_out.id;
            mem_last[wr_ptr] <= tag_out.last;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fcnt   <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == LAST_SLOT) ? '0 : wr_ptr + AW'(1);
            if (pop)  rd_ptr <= (rd_ptr == LAST_SLOT) ? '0 : rd_ptr + AW'(1);
            if (push && !pop)      fcnt <= fcnt + CW'(1);
            else if (!push && pop) fcnt <= fcnt - CW'(1);
        end
    end

    assign ks_valid = (fcnt != '0);
    assign ks_data  = ks_valid ? mem_data[rd_ptr] : '0;
    assign ks_id    = ks_valid & mem_id[rd_ptr];
    assign ks_last  = ks_valid & mem_last[rd_ptr];
    assign busy     = (state != S_IDLE) || (inflight != '0) || (fcnt != '0);

endmodule

// File: tb/tb_chacha_keystream_ctrl.sv
// Bench for chacha_keystream_ctrl: a fake fixed-latency core, a scoreboard built
// from each accepted request, table-driven bursts, corner sequences and a
// randomized phase with random consumer backpressure.
module tb_chacha_keystream_ctrl;
    localparam int CORE_LAT   = 12;
    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W      = 8;
    localparam logic [127:0] SIGMA = 128'h61707865_3320646e_79622d32_6b206574;

    logic               clk = 1'b0;
    logic               rst;
    logic [255:0]       key;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [191:0]       req_nonce;
    logic [63:0]        req_ctr;
    logic [2*LEN_W-1:0] req_len;
    logic [511:0]       core_state;
    logic               core_issue;
    logic [511:0]       core_result = '0;
    logic               ks_valid;
    logic               ks_ready = 1'b0;
    logic [511:0]       ks_data;
    logic               ks_id;
    logic               ks_last;
    logic               busy;

    chacha_keystream_ctrl #(.CORE_LAT(CORE_LAT), .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst(rst), .key(key), .req_valid(req_valid), .req_ready(req_ready),
        .req_nonce(req_nonce), .req_ctr(req_ctr), .req_len(req_len),
        .core_state(core_state), .core_issue(core_issue), .core_result(core_result),
        .ks_valid(ks_valid), .ks_ready(ks_ready), .ks_data(ks_data), .ks_id(ks_id),
        .ks_last(ks_last), .busy(busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Fake core: result is the bitwise inverse of the state issued CORE_LAT cycles earlier.
    logic [511:0] hist[$];
    always @(negedge clk) begin
        hist.push_back(core_state);
        if (hist.size() > CORE_LAT) core_result = ~hist.pop_front();
    end

    // Consumer: fixed or random ready, changed just after each rising edge.
    logic rmode = 1'b0;
    logic ready_fixed = 1'b1;
    always @(posedge clk) begin
        #1;
        ks_ready = rmode ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    typedef struct {
        logic [511:0] d;
        logic         id;
        logic         last;
    } beat_t;

    beat_t        exp_q[$];
    logic [511:0] iss_q[$];
    int           iss_cyc_q[$];
    int           acc_order[$];
    int n_issue = 0, n_beat = 0, n_acc = 0;
    int acc_cyc = 0, first_lat = -1;
    bit first_pending = 0, seen_ks = 0;

    // Monitor: expected blocks come straight from the request fields and key.
    always @(negedge clk) begin
        beat_t        b;
        logic [511:0] st;
        int           len;
        if (core_issue) begin
            n_issue++;
            iss_cyc_q.push_back(cyc);
            if (iss_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL issue_extra: got state %0h expected no issue", core_state);
            end else chk("core_state", core_state, iss_q.pop_front());
        end
        if (ks_valid) seen_ks = 1;
        if (first_pending && ks_valid) begin
            first_lat = cyc - acc_cyc;
            first_pending = 0;
        end
        if (ks_valid && ks_ready) begin
            n_beat++;
            if (exp_q.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL beat_extra: got id %0d data %0h expected no beat", ks_id, ks_data);
            end else begin
                b = exp_q.pop_front();
                chk("ks_data", ks_data, b.d);
                chk("ks_id", 512'(ks_id), 512'(b.id));
                chk("ks_last", 512'(ks_last), 512'(b.last));
            end
        end
        for (int r = 0; r < 2; r++) begin
            if (req_ready[r]) begin
                n_acc++;
                acc_order.push_back(r);
                acc_cyc = cyc;
                first_pending = 1;
                len = int'(req_len[LEN_W*r +: LEN_W]);
                for (int i = 0; i < len; i++) begin
                    st = {SIGMA, key, req_ctr[32*r +: 32] + 32'(i), req_nonce[96*r +: 96]};
                    iss_q.push_back(st);
                    b.d = ~st;
                    b.id = 1'(r);
                    b.last = (i == len - 1);
                    exp_q.push_back(b);
                end
            end
        end
        if (rst) begin
            exp_q.delete();
            iss_q.delete();
        end
    end

    task automatic wait_accept(input int r);
        bit got = 0;
        for (int i = 0; i < 400 && !got; i++) begin
            @(negedge clk);
            if (req_ready[r]) got = 1;
        end
        if (!got) begin
            n_checks++; n_fail++;
            $display("FAIL accept_timeout: got no req_ready[%0d] expected a pulse", r);
        end
        @(posedge clk); #1;
        req_valid[r] = 1'b0;
    endtask

    task automatic set_req(input int r, input logic [31:0] c, input int len, input logic [95:0] n);
        req_ctr[32*r +: 32]       = c;
        req_nonce[96*r +: 96]     = n;
        req_len[LEN_W*r +: LEN_W] = LEN_W'(len);
        req_valid[r]              = 1'b1;
    endtask

    task automatic do_req(input int r, input logic [31:0] c, input int len, input logic [95:0] n);
        @(posedge clk); #1;
        set_req(r, c, len, n);
        wait_accept(r);
    endtask

    task automatic drain();
        bit done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) done = 1;
        end
        chk("drain_done", 512'(done), 512'(1));
    endtask

    function automatic logic [255:0] rand_key();
        logic [255:0] k;
        for (int i = 0; i < 8; i++) k[32*i +: 32] = $urandom();
        return k;
    endfunction

    typedef struct {
        int           r;
        logic [31:0]  ctr;
        int           len;
        logic [95:0]  nonce;
        logic [255:0] key;
        int           exp_beats;
        int           exp_lat;
    } vec_t;

    vec_t vt[5];

    initial begin
        int bi, bb, ba, len, r;
        logic [31:0] c;
        logic [255:0] k1;

        vt[0] = '{0, 32'd5,          1,  96'h111_222_333, {8{32'h0badf00d}}, 1,  2 + CORE_LAT};
        vt[1] = '{1, 32'hFFFF_FFFE,  4,  96'hAAAA_BBBB_CCCC, {8{32'h13579bdf}}, 4, 2 + CORE_LAT};
        vt[2] = '{0, 32'h100,        0,  96'h5,        {8{32'h2468ace0}}, 0,  -1};
        vt[3] = '{1, 32'd7,          3,  96'hDEAD_BEEF, {8{32'h5a5a5a5a}}, 3,  2 + CORE_LAT};
        vt[4] = '{0, 32'd0,          20, 96'h1234_5678, {8{32'hc3c3a1a1}}, 20, 2 + CORE_LAT};

        rst = 1'b1; key = '0; req_valid = '0; req_nonce = '0; req_ctr = '0; req_len = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 512'(req_ready), 512'(0));
        chk("rst_core_issue", 512'(core_issue), 512'(0));
        chk("rst_core_state", core_state, 512'(0));
        chk("rst_ks", {ks_data, ks_valid, ks_id, ks_last}, '0);
        chk("rst_busy", 512'(busy), 512'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Both requesters from reset: req0 first, then req1; then again to see the pointer alternate.
        for (int round = 0; round < 2; round++) begin
            key = rand_key();
            @(posedge clk); #1;
            set_req(0, 32'h40 + 32'(round), 2, 96'h0A0A);
            set_req(1, 32'h80 + 32'(round), 2, 96'h0B0B);
            wait_accept(0);
            wait_accept(1);
            drain();
        end
        chk("rr_order_len", 512'(acc_order.size()), 512'(4));
        if (acc_order.size() == 4) begin
            chk("rr_order0", 512'(acc_order[0]), 512'(0));
            chk("rr_order1", 512'(acc_order[1]), 512'(1));
            chk("rr_order2", 512'(acc_order[2]), 512'(0));
            chk("rr_order3", 512'(acc_order[3]), 512'(1));
        end

        // Table of single bursts with an always-ready consumer.
        for (int i = 0; i < 5; i++) begin
            rmode = 1'b0; ready_fixed = 1'b1;
            key = vt[i].key;
            iss_cyc_q.delete();
            first_pending = 0; first_lat = -1;
            bi = n_issue; bb = n_beat; ba = n_acc;
            do_req(vt[i].r, vt[i].ctr, vt[i].len, vt[i].nonce);
            drain();
            chk("v_beats", 512'(n_beat - bb), 512'(vt[i].exp_beats));
            chk("v_issues", 512'(n_issue - bi), 512'(vt[i].exp_beats));
            chk("v_accepts", 512'(n_acc - ba), 512'(1));
            if (vt[i].exp_lat >= 0) chk("v_first_lat", 512'(first_lat), 512'(vt[i].exp_lat));
            if (vt[i].len > 1 && iss_cyc_q.size() > 1)
                chk("v_issue_contig", 512'(iss_cyc_q[$] - iss_cyc_q[0]), 512'(vt[i].len - 1));
            chk("v_busy_idle", 512'(busy), 512'(0));
        end

        // Credit limit: with the consumer stalled only FIFO_DEPTH blocks may be outstanding.
        ready_fixed = 1'b0;
        key = rand_key();
        bi = n_issue; bb = n_beat;
        do_req(0, 32'h1000, 40, 96'hC0FFEE);
        repeat (60) @(negedge clk);
        chk("credit_issues", 512'(n_issue - bi), 512'(FIFO_DEPTH));
        chk("credit_ks_valid", 512'(ks_valid), 512'(1));
        ready_fixed = 1'b1;
        drain();
        chk("credit_beats", 512'(n_beat - bb), 512'(40));

        // Key change right after acceptance only affects the next burst.
        k1 = rand_key();
        key = k1;
        do_req(1, 32'h77, 6, 96'h4242);
        key = ~k1;
        drain();
        bb = n_beat;
        do_req(0, 32'h99, 2, 96'h4343);
        drain();
        chk("key_next_beats", 512'(n_beat - bb), 512'(2));

        // Mid-burst reset: outputs clear next cycle and stale core results are discarded.
        key = rand_key();
        bi = n_issue;
        do_req(1, 32'h500, 20, 96'h9999);
        for (int i = 0; i < 100 && (n_issue - bi) < 5; i++) @(negedge clk);
        chk("rst_mid_reached", 512'((n_issue - bi) >= 5), 512'(1));
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1; rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_issue", {core_state, core_issue}, '0);
        chk("rst_mid_ks", {ks_data, ks_valid, ks_id, ks_last}, '0);
        chk("rst_mid_busy", 512'({busy, req_ready}), 512'(0));
        seen_ks = 0;
        repeat (CORE_LAT + 6) @(negedge clk);
        chk("rst_mid_no_stale", 512'(seen_ks), 512'(0));
        bb = n_beat;
        do_req(0, 32'h600, 3, 96'h7777);
        drain();
        chk("rst_mid_after", 512'(n_beat - bb), 512'(3));

        // Randomized bursts with random backpressure.
        rmode = 1'b1;
        for (int i = 0; i < 12; i++) begin
            r = int'($urandom_range(0, 1));
            len = int'($urandom_range(0, 24));
            c = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15)) : $urandom();
            key = rand_key();
            bb = n_beat;
            do_req(r, c, len, {$urandom(), $urandom(), $urandom()});
            drain();
            chk("rnd_beats", 512'(n_beat - bb), 512'(len));
        end
        rmode = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
